nor_share_sched: RTL and testbench
==================================

// Module: nor_share_sched
// PURPOSE
//  Round-robin scheduler sharing one NOR gate instance (SN74LS02 section, tpd 1/10/15 ns) among N requesters.
//  Grants one request at a time, drives the gate inputs, waits a fixed settle time covering worst-case tpd,
//  then returns the sampled output. Also counts 0->1 output transitions, the energy-consuming events.
//  Sits between stimulus/test logic and the gate-level NOR instance in the power/cost evaluation benches.
// PARAMETERS
//  N           4   number of requesters (>=2)
//  SETTLE_CYC  2   clocks between driving gate inputs and sampling gate_y (>=1; 2 covers 15 ns at 10 ns clk)
//  CNT_W       16  width of rise_cnt
// PORTS
//  clk        in   1      single clock, rising edge
//  reset      in   1      synchronous, active-high
//  req_valid  in   N      request pending, one bit per requester
//  req_a      in   N      operand A per requester; held stable while valid
//  req_b      in   N      operand B per requester; held stable while valid
//  req_ready  out  N      one-hot accept, combinational; transfer on valid&ready
//  gate_a     out  1      to NOR input A (registered)
//  gate_b     out  1      to NOR input B (registered)
//  gate_y     in   1      from NOR output Y
//  rsp_valid  out  1      one-cycle result pulse
//  rsp_id     out  clog2(N) requester index of result
//  rsp_y      out  1      sampled gate_y
//  busy       out  1      high when state != IDLE
//  cnt_clr    in   1      synchronous clear of rise_cnt
//  rise_cnt   out  CNT_W  saturating count of gate_y 0->1 transitions
// BEHAVIOUR
//  Reset: state IDLE, ptr=0, gate_a=gate_b=0, rsp_valid=0, rsp_id=0, rsp_y=0, rise_cnt=0, y_q=1, busy=0.
//  FSM IDLE -> SETTLE -> RESP -> IDLE.
//  - IDLE: req_ready = one-hot of first valid at index >= ptr, wrapping; 0 if none valid.
//    On accept (cycle T): latch id; gate_a/gate_b <= req_a[id]/req_b[id]; ptr <= (id+1) mod N;
//    timer <= SETTLE_CYC; go SETTLE.
//  - SETTLE: timer decrements each clock; on timer==1 sample rsp_y <= gate_y, rsp_id <= id, go RESP.
//  - RESP: rsp_valid=1 for exactly this cycle; req_ready=0; next IDLE.
//  Latency: gate inputs valid from T+1; rsp_valid in cycle T+1+SETTLE_CYC. Throughput: 1 op / (SETTLE_CYC+2) clk.
//  req_ready is 0 in all states except IDLE. A request dropped before accept has no effect.
//  gate_a/gate_b hold last operands until the next accept (no needless toggling -> no spurious energy).
//  Rise counter: y_q <= gate_y every clock; rise = gate_y & ~y_q. Counts in every state.
//    Saturates at 2^CNT_W-1. cnt_clr wins over a simultaneous rise (result 0).
//    X/Z on gate_y counts as no rise.
//  reset mid-operation: in-flight op abandoned, no rsp_valid, all registers to reset values.
// TESTING
//  1. SETTLE_CYC=2; only req 2 valid, a=0,b=0, accept T -> gate_a=gate_b=0 at T+1; rsp_valid at T+3, id=2, y=1.
//  2. All 4 valid continuously from reset, a=b=1 -> grant order 0,1,2,3,0; accepts 4 clk apart; each rsp_y=0.
//  3. Ops (1,0),(0,0),(0,1),(0,0) on 15 ns-delay gate, 10 ns clk -> rsp_y 0,1,0,1; rise_cnt ends at 2.
//  4. CNT_W=2, 5 rising ops -> rise_cnt holds 3; cnt_clr in the same cycle as a rise -> rise_cnt=0.
//  5. reset high during SETTLE -> no rsp_valid; next cycle busy=0, gate_a=gate_b=0, next grant goes to lowest valid.
//  6. SETTLE_CYC=1 with 15 ns gate, 10 ns clk, (0,0) after (1,0) -> scoreboard flags stale rsp_y=0 (insufficient settle).

Source files
------------

// File: rtl/nor_share_sched.sv
// nor_share_sched: round-robin arbiter time-sharing one NOR gate among N requesters,
// with a fixed settle wait before sampling and a saturating count of output rises.
module nor_share_sched #(
    parameter int N          = 4,
    parameter int SETTLE_CYC = 2,
    parameter int CNT_W      = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N-1:0]         req_valid,
    input  logic [N-1:0]         req_a,
    input  logic [N-1:0]         req_b,
    output logic [N-1:0]         req_ready,
    output logic                 gate_a,
    output logic                 gate_b,
    input  logic                 gate_y,
    output logic                 rsp_valid,
    output logic [$clog2(N)-1:0] rsp_id,
    output logic                 rsp_y,
    output logic                 busy,
    input  logic                 cnt_clr,
    output logic [CNT_W-1:0]     rise_cnt
);
    localparam int IW = $clog2(N);
    localparam int TW = $clog2(SETTLE_CYC + 1);

    typedef enum logic [1:0] {IDLE, SETTLE, RESP} state_t;

    state_t        state, state_nx;
    logic [IW-1:0] ptr, id, gid;
    logic [TW-1:0] timer;
    logic          accept, y_q, rise;
    int            d, best_d;

    // winner is the valid requester at the smallest cyclic distance from ptr
    always_comb begin
        gid    = '0;
        best_d = N;
        d      = 0;
        for (int j = 0; j < N; j++) begin
            d = (j + N - int'(ptr)) % N;
            if (req_valid[j] && d < best_d) begin
                best_d = d;
                gid    = IW'(j);
            end
        end
    end

    assign accept    = (state == IDLE) && |req_valid;
    assign req_ready = accept ? (N'(1) << gid) : '0;
    assign busy      = state != IDLE;
    assign rsp_valid = state == RESP;
    assign rise      = gate_y & ~y_q;

    always_comb begin
        state_nx = state;
        state_nx = (state == IDLE)   ? (accept ? SETTLE : IDLE) :
                   (state == SETTLE) ? ((timer == TW'(1)) ? RESP : SETTLE) : IDLE;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            ptr    <= '0;
            id     <= '0;
            timer  <= '0;
            gate_a <= 1'b0;
            gate_b <= 1'b0;
            rsp_id <= '0;
            rsp_y  <= 1'b0;
        end else begin
            state <= state_nx;
            if (accept) begin
                id     <= gid;
                gate_a <= req_a[gid];
                gate_b <= req_b[gid];
                ptr    <= (gid == IW'(N - 1)) ? '0 : gid + IW'(1);
                timer  <= TW'(SETTLE_CYC);
            end
            if (state == SETTLE) begin
                timer <= timer - TW'(1);
                if (timer == TW'(1)) begin
                    rsp_y  <= gate_y;
                    rsp_id <= id;
                end
            end
        end
    end

    // y_q resets high so a gate already at 1 out of reset is not counted as a rise
    always_ff @(posedge clk) begin
        if (reset) begin
            y_q      <= 1'b1;
            rise_cnt <= '0;
        end else begin
            y_q <= gate_y;
            if (cnt_clr)
                rise_cnt <= '0;
            else if (rise && rise_cnt != '1)
                rise_cnt <= rise_cnt + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_nor_share_sched.sv
// tb_nor_share_sched: randomized requesters against a transaction-level model of the
// shared-NOR scheduler; a 15 ns NOR model closes the loop on a 10 ns clock.
module tb_nor_share_sched;
    localparam int N   = 4;
    localparam int SC  = 2;
    localparam int CW  = 3;
    localparam int MAX = (1 << CW) - 1;

    logic          clk = 1'b0, reset = 1'b1, cnt_clr = 1'b0;
    logic [N-1:0]  req_valid = '0, req_a = '0, req_b = '0, req_ready;
    logic          gate_a, gate_b, gate_y = 1'b1;
    logic          rsp_valid, rsp_y, busy;
    logic [1:0]    rsp_id;
    logic [CW-1:0] rise_cnt;

    int   checks = 0, errors = 0;
    int   mptr, rem, cur_id, mcnt, g, granted, rst_cnt;
    logic exp_a, exp_b, cur_y, prev_y, rise, after_rst, want_rst;

    always #5 clk = ~clk;
    always @(gate_a or gate_b) gate_y <= #15 ~(gate_a | gate_b);

    nor_share_sched #(.N(N), .SETTLE_CYC(SC), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
        .req_ready(req_ready), .gate_a(gate_a), .gate_b(gate_b), .gate_y(gate_y),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_y(rsp_y), .busy(busy),
        .cnt_clr(cnt_clr), .rise_cnt(rise_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // first pending requester going round from the model's pointer, -1 if none
    function automatic int pick();
        for (int k = 0; k < N; k++)
            if (req_valid[(mptr + k) % N]) return (mptr + k) % N;
        return -1;
    endfunction

    initial begin
        mptr = 0; rem = 0; mcnt = 0; cur_id = 0; granted = -1; rst_cnt = 0;
        exp_a = 1'b0; exp_b = 1'b0; cur_y = 1'b0; prev_y = 1'b1;
        after_rst = 1'b1; want_rst = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            if (granted >= 0) req_valid[granted] = 1'b0;
            granted = -1;
            if (c % 500 == 250) want_rst = 1'b1;
            reset = (c < 3) || (want_rst && rem >= 2);
            if (reset && c >= 3) begin
                want_rst = 1'b0;
                rst_cnt++;
            end
            cnt_clr = ($urandom_range(0, 299) == 0);
            for (int i = 0; i < N; i++) begin
                if (req_valid[i]) begin
                    if ($urandom_range(0, 19) == 0) req_valid[i] = 1'b0;
                end else if (c >= 3 && $urandom_range(0, 3) == 0) begin
                    req_valid[i] = 1'b1;
                    req_a[i] = ($urandom_range(0, 2) == 0);
                    req_b[i] = ($urandom_range(0, 2) == 0);
                end
            end
            #1;
            g = pick();
            chk("busy", busy, rem > 0);
            chk("rsp_valid", rsp_valid, rem == 1);
            chk("req_ready", req_ready, (rem == 0 && g >= 0) ? (1 << g) : 0);
            chk("gate_a", gate_a, exp_a);
            chk("gate_b", gate_b, exp_b);
            chk("rise_cnt", rise_cnt, mcnt);
            if (rem == 1) begin
                chk("rsp_id", rsp_id, cur_id);
                chk("rsp_y", rsp_y, cur_y);
            end
            if (after_rst) begin
                chk("rst_rsp_id", rsp_id, 0);
                chk("rst_rsp_y", rsp_y, 0);
                after_rst = 1'b0;
            end
            if (reset) begin
                rem = 0; mptr = 0; mcnt = 0;
                exp_a = 1'b0; exp_b = 1'b0; prev_y = 1'b1;
                after_rst = 1'b1;
            end else begin
                rise = (gate_y === 1'b1) && (prev_y === 1'b0);
                prev_y = gate_y;
                if (cnt_clr) mcnt = 0;
                else if (rise && mcnt < MAX) mcnt++;
                if (rem > 0) rem--;
                else if (g >= 0) begin
                    rem = SC + 1;
                    cur_id = g;
                    exp_a = req_a[g];
                    exp_b = req_b[g];
                    cur_y = ~(exp_a | exp_b);
                    mptr = (g + 1) % N;
                    granted = g;
                end
            end
        end
        chk("mid_op_resets", rst_cnt > 0, 1);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
